// File: rtl/branch_predictor_param.sv
// IF-stage branch predictor: direct-mapped tagged BTB plus saturating direction counters,
// with optional gshare history and resolution statistics.
module branch_predictor_param #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned CTR_WIDTH  = 2,
  parameter int unsigned MODE       = 1,
  parameter int unsigned HIST_BITS  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic [ADDR_WIDTH-1:0] pred_npc,
  output logic                  pred_taken,
  output logic                  pred_hit,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic [ADDR_WIDTH-1:0] upd_target,
  input  logic                  upd_taken,
  input  logic                  upd_mispredict,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispredicts
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W   = ADDR_WIDTH - INDEX_BITS - 2;
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;

  logic                  r_valid  [ENTRIES];
  logic [TAG_W-1:0]      r_tag    [ENTRIES];
  logic [ADDR_WIDTH-1:0] r_target [ENTRIES];
  logic [CTR_WIDTH-1:0]  r_ctr    [ENTRIES];
  logic [HIST_BITS-1:0]  r_ghr;
  logic [31:0]           r_stat_br;
  logic [31:0]           r_stat_mp;

  logic [INDEX_BITS-1:0] w_lk_idx;
  logic [TAG_W-1:0]      w_lk_tag;
  logic [INDEX_BITS-1:0] w_lk_cidx;
  logic                  w_lk_dir;
  logic [INDEX_BITS-1:0] w_up_idx;
  logic [TAG_W-1:0]      w_up_tag;
  logic [INDEX_BITS-1:0] w_up_cidx;
  logic [INDEX_BITS-1:0] w_hist_ext;
  logic [CTR_WIDTH-1:0]  w_ctr_cur;
  logic [CTR_WIDTH-1:0]  w_ctr_next;
  logic [HIST_BITS-1:0]  w_ghr_next;
  logic                  w_unused_lsbs;

  // PC bits [1:0] never participate: instructions are word aligned.
  assign w_unused_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign w_hist_ext = INDEX_BITS'(r_ghr);

  assign w_lk_idx  = lookup_pc[INDEX_BITS+1:2];
  assign w_lk_tag  = lookup_pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign w_lk_cidx = (MODE == 2) ? (w_lk_idx ^ w_hist_ext) : w_lk_idx;
  assign w_lk_dir  = (MODE == 0) ? 1'b1 : r_ctr[w_lk_cidx][CTR_WIDTH-1];

  assign w_up_idx  = upd_pc[INDEX_BITS+1:2];
  assign w_up_tag  = upd_pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign w_up_cidx = (MODE == 2) ? (w_up_idx ^ w_hist_ext) : w_up_idx;

  // Lookup reads pre-update state only; a same-cycle write becomes visible next cycle.
  always_comb begin
    pred_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    pred_taken = pred_hit && w_lk_dir;
    pred_npc   = pred_taken ? r_target[w_lk_idx] : lookup_pc + ADDR_WIDTH'(4);
  end

  always_comb begin
    w_ctr_cur  = r_ctr[w_up_cidx];
    w_ctr_next = w_ctr_cur;
    if (upd_taken) begin
      if (w_ctr_cur != CTR_MAX) w_ctr_next = w_ctr_cur + CTR_WIDTH'(1);
    end else begin
      if (w_ctr_cur != '0) w_ctr_next = w_ctr_cur - CTR_WIDTH'(1);
    end
  end

  // Shift form stays legal when HIST_BITS is 1.
  assign w_ghr_next = (r_ghr << 1) | HIST_BITS'(upd_taken);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= CTR_INIT;
      end
      r_ghr     <= '0;
      r_stat_br <= '0;
      r_stat_mp <= '0;
    end else if (upd_valid) begin
      r_stat_br <= r_stat_br + 32'd1;
      if (upd_mispredict) r_stat_mp <= r_stat_mp + 32'd1;
      if (upd_taken) r_valid[w_up_idx] <= 1'b1;
      if (MODE != 0) r_ctr[w_up_cidx] <= w_ctr_next;
      if (MODE == 2) r_ghr <= w_ghr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && upd_valid && upd_taken) begin
      r_tag[w_up_idx]    <= w_up_tag;
      r_target[w_up_idx] <= upd_target;
    end
  end

  assign stat_branches    = r_stat_br;
  assign stat_mispredicts = r_stat_mp;

endmodule

// File: tb/tb_branch_predictor_param.sv
// Bench for branch_predictor_param: a bimodal and a gshare instance share one stimulus stream
// and are checked every cycle against an abstract model, plus literal expectations.
module tb_branch_predictor_param;

  logic        clk;
  logic        rst;
  logic [15:0] lookup_pc;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic [15:0] upd_target;
  logic        upd_taken;
  logic        upd_mispredict;

  logic [15:0] n1_npc, n2_npc;
  logic        n1_taken, n2_taken, n1_hit, n2_hit;
  logic [31:0] n1_sb, n2_sb, n1_sm, n2_sm;

  int checks   = 0;
  int failures = 0;

  branch_predictor_param #(.ADDR_WIDTH(16), .INDEX_BITS(6), .CTR_WIDTH(2), .MODE(1), .HIST_BITS(6)) u_bim (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .pred_npc(n1_npc), .pred_taken(n1_taken), .pred_hit(n1_hit),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .stat_branches(n1_sb), .stat_mispredicts(n1_sm)
  );

  branch_predictor_param #(.ADDR_WIDTH(16), .INDEX_BITS(6), .CTR_WIDTH(2), .MODE(2), .HIST_BITS(6)) u_gsh (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .pred_npc(n2_npc), .pred_taken(n2_taken), .pred_hit(n2_hit),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .stat_branches(n2_sb), .stat_mispredicts(n2_sm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Abstract model: an entry hits when the last taken branch written at that
  // index has the same word address; counters are plain saturating integers.
  bit          m_ready = 1'b0;
  bit          m_valid [2][64];
  logic [15:0] m_owner [2][64];
  logic [15:0] m_tgt   [2][64];
  int          m_ctr   [2][64];
  int          m_hist  [2];
  logic [31:0] m_br, m_mp;

  function automatic int mode_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic int slot(input logic [15:0] pc);
    return int'(pc[15:2]) % 64;
  endfunction

  function automatic int cidx(input int k, input logic [15:0] pc);
    return (mode_of(k) == 2) ? (slot(pc) ^ m_hist[k]) : slot(pc);
  endfunction

  function automatic bit exp_hit(input int k, input logic [15:0] pc);
    return m_valid[k][slot(pc)] && (m_owner[k][slot(pc)][15:2] == pc[15:2]);
  endfunction

  function automatic bit exp_taken(input int k, input logic [15:0] pc);
    return exp_hit(k, pc) && (m_ctr[k][cidx(k, pc)] >= 2);
  endfunction

  function automatic logic [15:0] exp_npc(input int k, input logic [15:0] pc);
    logic [15:0] seq;
    seq = pc + 16'd4;
    return exp_taken(k, pc) ? m_tgt[k][slot(pc)] : seq;
  endfunction

  function automatic int ctr_step(input int v, input bit t);
    if (t) return (v >= 3) ? 3 : v + 1;
    return (v <= 0) ? 0 : v - 1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ready <= 1'b1;
      for (int k = 0; k < 2; k++) begin
        for (int e = 0; e < 64; e++) begin
          m_valid[k][e] <= 1'b0;
          m_ctr[k][e]   <= 1;
        end
        m_hist[k] <= 0;
      end
      m_br <= '0;
      m_mp <= '0;
    end else if (m_ready && upd_valid) begin
      for (int k = 0; k < 2; k++) begin
        if (upd_taken) begin
          m_valid[k][slot(upd_pc)] <= 1'b1;
          m_owner[k][slot(upd_pc)] <= upd_pc;
          m_tgt[k][slot(upd_pc)]   <= upd_target;
        end
        m_ctr[k][cidx(k, upd_pc)] <= ctr_step(m_ctr[k][cidx(k, upd_pc)], upd_taken);
        if (mode_of(k) == 2) m_hist[k] <= (m_hist[k] * 2 + int'(upd_taken)) % 64;
      end
      m_br <= m_br + 32'd1;
      if (upd_mispredict) m_mp <= m_mp + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      chk("bim_hit",   {31'd0, n1_hit},   {31'd0, exp_hit(0, lookup_pc)});
      chk("bim_taken", {31'd0, n1_taken}, {31'd0, exp_taken(0, lookup_pc)});
      chk("bim_npc",   {16'd0, n1_npc},   {16'd0, exp_npc(0, lookup_pc)});
      chk("bim_sb",    n1_sb, m_br);
      chk("bim_sm",    n1_sm, m_mp);
      chk("gsh_hit",   {31'd0, n2_hit},   {31'd0, exp_hit(1, lookup_pc)});
      chk("gsh_taken", {31'd0, n2_taken}, {31'd0, exp_taken(1, lookup_pc)});
      chk("gsh_npc",   {16'd0, n2_npc},   {16'd0, exp_npc(1, lookup_pc)});
      chk("gsh_sb",    n2_sb, m_br);
      chk("gsh_sm",    n2_sm, m_mp);
    end
  end

  task automatic to_pos;
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg;
    @(negedge clk);
  endtask

  task automatic upd(input logic [15:0] pc, input logic [15:0] tgt, input bit t, input bit mp);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_target     = tgt;
    upd_taken      = t;
    upd_mispredict = mp;
    to_pos();
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    to_pos();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; upd_valid = 1'b0; upd_pc = '0; upd_target = '0;
    upd_taken = 1'b0; upd_mispredict = 1'b0; lookup_pc = 16'h8000;
    to_pos();
    to_pos();
    rst = 1'b0;

    // Reset state
    at_neg();
    chk("t1_hit",   {31'd0, n1_hit},   32'd0);
    chk("t1_taken", {31'd0, n1_taken}, 32'd0);
    chk("t1_npc",   {16'd0, n1_npc},   32'h8004);
    chk("t1_sb",    n1_sb, 32'd0);
    chk("t1_sm",    n1_sm, 32'd0);

    // First taken update; same-cycle lookup must see the old state
    to_pos();
    lookup_pc = 16'h8010;
    upd_valid = 1'b1; upd_pc = 16'h8010; upd_target = 16'h8040; upd_taken = 1'b1;
    at_neg();
    chk("t2_rdw_npc",   {16'd0, n1_npc},   32'h8014);
    chk("t2_rdw_taken", {31'd0, n1_taken}, 32'd0);
    to_pos();
    upd_valid = 1'b0;
    at_neg();
    chk("t2_hit",   {31'd0, n1_hit},   32'd1);
    chk("t2_taken", {31'd0, n1_taken}, 32'd1);
    chk("t2_npc",   {16'd0, n1_npc},   32'h8040);
    to_pos();

    // Saturation: 4 more taken (total 5) then two not-taken
    for (int i = 0; i < 4; i++) upd(16'h8010, 16'h8040, 1'b1, 1'b0);
    upd(16'h8010, 16'h8040, 1'b0, 1'b0);
    at_neg();
    chk("t3_nt1_taken", {31'd0, n1_taken}, 32'd1);
    chk("t3_nt1_npc",   {16'd0, n1_npc},   32'h8040);
    to_pos();
    upd(16'h8010, 16'h8040, 1'b0, 1'b0);
    at_neg();
    chk("t3_nt2_hit",   {31'd0, n1_hit},   32'd1);
    chk("t3_nt2_taken", {31'd0, n1_taken}, 32'd0);
    chk("t3_nt2_npc",   {16'd0, n1_npc},   32'h8014);
    to_pos();

    // Aliasing at idx 4
    lookup_pc = 16'h8110;
    at_neg();
    chk("t4_alias_hit", {31'd0, n1_hit}, 32'd0);
    chk("t4_alias_npc", {16'd0, n1_npc}, 32'h8114);
    to_pos();
    upd(16'h8110, 16'h8200, 1'b1, 1'b0);
    at_neg();
    chk("t4_new_hit", {31'd0, n1_hit}, 32'd1);
    chk("t4_new_npc", {16'd0, n1_npc}, 32'h8200);
    lookup_pc = 16'h8010;
    at_neg();
    chk("t4_old_hit", {31'd0, n1_hit}, 32'd0);
    chk("t4_old_npc", {16'd0, n1_npc}, 32'h8014);
    to_pos();

    // Wrap and statistics
    do_reset();
    lookup_pc = 16'hFFFC;
    at_neg();
    chk("t5_wrap_npc", {16'd0, n1_npc}, 32'h0000);
    chk("t5_wrap_hit", {31'd0, n1_hit}, 32'd0);
    to_pos();
    for (int k = 0; k < 7; k++) begin
      upd(16'h8030 + 16'(4 * k), 16'h9000 + 16'(k), (k % 2) == 0, (k == 0) || (k == 2) || (k == 5));
      if (k == 1 || k == 4) begin
        upd_mispredict = 1'b1;
        to_pos();
        upd_mispredict = 1'b0;
      end
    end
    at_neg();
    chk("t5_sb", n1_sb, 32'd7);
    chk("t5_sm", n1_sm, 32'd3);
    chk("t5_sb_g", n2_sb, 32'd7);
    to_pos();

    // Gshare: alternating T/N at 0x8020
    do_reset();
    lookup_pc = 16'h8020;
    for (int k = 0; k < 16; k++) upd(16'h8020, 16'h8100, (k % 2) == 0, 1'b0);
    at_neg();
    chk("t6_g_taken0", {31'd0, n2_taken}, 32'd1);
    chk("t6_g_npc0",   {16'd0, n2_npc},   32'h8100);
    chk("t6_b_taken0", {31'd0, n1_taken}, 32'd0);
    chk("t6_b_npc0",   {16'd0, n1_npc},   32'h8024);
    to_pos();
    for (int k = 0; k < 4; k++) begin
      upd(16'h8020, 16'h8100, (k % 2) == 0, 1'b0);
      at_neg();
      chk("t6_g_hit",   {31'd0, n2_hit},   32'd1);
      chk("t6_g_taken", {31'd0, n2_taken}, (k % 2) == 0 ? 32'd0 : 32'd1);
      chk("t6_g_npc",   {16'd0, n2_npc},   (k % 2) == 0 ? 32'h8024 : 32'h8100);
      to_pos();
    end

    // Reset overrides a same-cycle update
    rst = 1'b1;
    upd(16'h8020, 16'h8100, 1'b1, 1'b1);
    rst = 1'b0;
    at_neg();
    chk("t6_rst_hit_b", {31'd0, n1_hit}, 32'd0);
    chk("t6_rst_hit_g", {31'd0, n2_hit}, 32'd0);
    chk("t6_rst_npc",   {16'd0, n2_npc}, 32'h8024);
    chk("t6_rst_sb",    n2_sb, 32'd0);
    chk("t6_rst_sm",    n1_sm, 32'd0);
    to_pos();
    to_pos();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
